gpio_mult_sequencer: RTL

//  Bus master that sits directly upstream of the GPIO multiplier peripheral and drives its strobe bus.
//  - Takes (A1,A2) jobs on a valid/ready port.
//  - Per job: writes A1 and A2, writes the start register, polls status, then reads product W and ones-count L.
//  - Returns results on a valid/ready port.
//  - Peripheral map (decided): A1 0x037F, A2 0x0388, W 0x0390, L 0x0398, CTRL/STATUS 0x03A0.
//  - STATUS[1] is ready (1 = done); STATUS[0] is valid (1 = product fits in 32 bits).

---
 rtl/gpio_mult_pkg.sv | 51 +++++
 rtl/gpio_mult_sequencer_if.sv | 23 ++
 rtl/gpio_bus_access.sv | 74 +++++++
 rtl/gpio_mult_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/gpio_mult_pkg.sv
// Shared definitions for the GPIO multiplier sequencer slice.
//   - Peripheral register map and STATUS bit positions.
//   - Job FSM state, bus-access phase and access-select encodings.
//   - zext24: widens a 24-bit operand to the 32-bit write bus.
package gpio_mult_pkg;

  localparam logic [15:0] ADDR_A1   = 16'h037F;
  localparam logic [15:0] ADDR_A2   = 16'h0388;
  localparam logic [15:0] ADDR_W    = 16'h0390;
  localparam logic [15:0] ADDR_L    = 16'h0398;
  localparam logic [15:0] ADDR_CTRL = 16'h03A0;

  // STATUS[0]: product fits in 32 bits, STATUS[1]: multiply done
  localparam int unsigned STAT_VALID = 0;
  localparam int unsigned STAT_READY = 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_A1,
    S_WR_A2,
    S_WR_GO,
    S_WAIT,
    S_POLL,
    S_GAP,
    S_RD_W,
    S_RD_L,
    S_OUT
  } state_t;

  typedef enum logic [1:0] {
    P_IDLE,
    P_SETUP,
    P_STROBE,
    P_HOLD
  } phase_t;

  typedef enum logic [2:0] {
    ACC_NONE,
    ACC_A1,
    ACC_A2,
    ACC_GO,
    ACC_POLL,
    ACC_W,
    ACC_L
  } acc_t;

  function automatic logic [31:0] zext24(input logic [23:0] v);
    return {8'h00, v};
  endfunction

endpackage

// File: rtl/gpio_mult_sequencer_if.sv
// Strobe bus between the sequencer (master) and the GPIO multiplier (slave).
//   saddress  16  register address
//   swr        1  write strobe
//   srd        1  read strobe
//   sdata_wr  32  write data
//   sdata_rd  32  read data
interface gpio_mult_sequencer_if;
  logic [15:0] saddress;
  logic        swr;
  logic        srd;
  logic [31:0] sdata_wr;
  logic [31:0] sdata_rd;

  modport master (
    output saddress, swr, srd, sdata_wr,
    input  sdata_rd
  );

  modport slave (
    input  saddress, swr, srd, sdata_wr,
    output sdata_rd
  );
endinterface

// File: rtl/gpio_bus_access.sv
// Single bus-access engine: SETUP (1) / STROBE (STROBE_CYCLES) / HOLD (1).
//   clk, n_reset       clock, async active-low reset
//   start              launch an access; honoured in idle or in HOLD (back-to-back)
//   rnw, addr, wdata   access descriptor, latched when the access launches
//   done               high during HOLD; rdata is valid in that cycle
//   rdata              read data (bus data, captured by the caller at end of HOLD)
//   saddress..sdata_rd strobe bus pins
module gpio_bus_access
  import gpio_mult_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        start,
  input  logic        rnw,
  input  logic [15:0] addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic [15:0] saddress,
  output logic        swr,
  output logic        srd,
  output logic [31:0] sdata_wr,
  input  logic [31:0] sdata_rd
);

  localparam int unsigned SW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

  phase_t        phase, phase_d;
  logic [SW-1:0] scnt;
  logic          rnw_q;
  logic          launch;

  assign launch = start && (phase == P_IDLE || phase == P_HOLD);

  always_comb begin
    phase_d = phase;
    unique case (phase)
      P_IDLE:   if (start) phase_d = P_SETUP;
      P_SETUP:  phase_d = P_STROBE;
      P_STROBE: if (32'(scnt) == STROBE_CYCLES - 1) phase_d = P_HOLD;
      P_HOLD:   phase_d = start ? P_SETUP : P_IDLE;
      default:  phase_d = P_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      phase    <= P_IDLE;
      scnt     <= '0;
      rnw_q    <= 1'b0;
      saddress <= '0;
      sdata_wr <= '0;
    end else begin
      phase <= phase_d;
      if (phase == P_STROBE) scnt <= scnt + 1'b1;
      else                   scnt <= '0;
      if (launch) begin
        saddress <= addr;
        sdata_wr <= wdata;
        rnw_q    <= rnw;
      end
    end
  end

  // Strobes decode straight from the phase register so an async reset
  // removes them in the same cycle.
  assign swr   = (phase == P_STROBE) && !rnw_q;
  assign srd   = (phase == P_STROBE) &&  rnw_q;
  assign done  = (phase == P_HOLD);
  assign rdata = sdata_rd;

endmodule

// File: rtl/gpio_mult_sequencer.sv
// Job sequencer driving the GPIO multiplier over its strobe bus.
//   clk, n_reset                 clock, async active-low reset
//   job_valid/job_ready          job handshake; job_a1/job_a2 operands (24 b)
//   res_valid/res_ready          result handshake
//   res_w, res_ones, res_ovf     product low word, ones count, overflow
//   res_timeout                  peripheral never reported ready
//   bus                          strobe bus (master side)
//   busy                         job in flight
//   job_count                    completed result handshakes (wraps)
module gpio_mult_sequencer
  import gpio_mult_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES  = 2,
  parameter int unsigned MIN_WAIT       = 4,
  parameter int unsigned POLL_GAP       = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [23:0] job_a1,
  input  logic [23:0] job_a2,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_w,
  output logic [23:0] res_ones,
  output logic        res_ovf,
  output logic        res_timeout,
  gpio_mult_sequencer_if.master bus,
  output logic        busy,
  output logic [15:0] job_count
);

  localparam int unsigned TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned WAIT_LAST = (MIN_WAIT > 0) ? MIN_WAIT - 1 : 0;
  localparam int unsigned GAP_LAST  = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;

  state_t        state, state_d;
  acc_t          acc_sel;
  logic          start, acc_rnw, done, abort, accept, tmo, kick;
  logic [15:0]   acc_addr;
  logic [31:0]   acc_wdata, rdata;
  logic [23:0]   a1_q, a2_q;
  logic [15:0]   wcnt;
  logic [TW-1:0] tcnt;
  logic [15:0]   saddress;
  logic          swr, srd;
  logic [31:0]   sdata_wr;

  assign accept    = (state == S_IDLE) && job_valid;
  assign tmo       = 32'(tcnt) >= TIMEOUT_CYCLES;
  assign job_ready = (state == S_IDLE);
  assign res_valid = (state == S_OUT);
  assign busy      = (state != S_IDLE);

  // Each access is launched in the cycle before its SETUP: from the previous
  // access's HOLD (done) or from the last idle cycle of WAIT/GAP, so accesses
  // run back-to-back. The first write is launched by a one-cycle kick after accept.
  always_comb begin
    state_d = state;
    acc_sel = ACC_NONE;
    abort   = 1'b0;
    unique case (state)
      S_IDLE: if (job_valid) state_d = S_WR_A1;
      S_WR_A1: begin
        if (kick) acc_sel = ACC_A1;
        else if (done) begin
          state_d = S_WR_A2;
          acc_sel = ACC_A2;
        end
      end
      S_WR_A2: if (done) begin
        state_d = S_WR_GO;
        acc_sel = ACC_GO;
      end
      S_WR_GO: if (done) begin
        if (MIN_WAIT == 0) begin
          state_d = S_POLL;
          acc_sel = ACC_POLL;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (tmo) begin
          state_d = S_OUT;
          abort   = 1'b1;
        end else if (32'(wcnt) == WAIT_LAST) begin
          state_d = S_POLL;
          acc_sel = ACC_POLL;
        end
      end
      S_POLL: if (done) begin
        if (rdata[STAT_READY]) begin
          state_d = S_RD_W;
          acc_sel = ACC_W;
        end else if (tmo) begin
          state_d = S_OUT;
          abort   = 1'b1;
        end else if (POLL_GAP == 0) begin
          acc_sel = ACC_POLL;
        end else begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (tmo) begin
          state_d = S_OUT;
          abort   = 1'b1;
        end else if (32'(wcnt) == GAP_LAST) begin
          state_d = S_POLL;
          acc_sel = ACC_POLL;
        end
      end
      S_RD_W: if (done) begin
        state_d = S_RD_L;
        acc_sel = ACC_L;
      end
      S_RD_L: if (done) state_d = S_OUT;
      S_OUT:  if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    acc_rnw   = 1'b0;
    acc_addr  = '0;
    acc_wdata = '0;
    unique case (acc_sel)
      ACC_A1: begin
        acc_addr  = ADDR_A1;
        acc_wdata = zext24(a1_q);
      end
      ACC_A2: begin
        acc_addr  = ADDR_A2;
        acc_wdata = zext24(a2_q);
      end
      ACC_GO:   acc_addr = ADDR_CTRL;
      ACC_POLL: begin
        acc_addr = ADDR_CTRL;
        acc_rnw  = 1'b1;
      end
      ACC_W: begin
        acc_addr = ADDR_W;
        acc_rnw  = 1'b1;
      end
      ACC_L: begin
        acc_addr = ADDR_L;
        acc_rnw  = 1'b1;
      end
      default: ;
    endcase
  end

  assign start = (acc_sel != ACC_NONE);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state       <= S_IDLE;
      kick        <= 1'b0;
      a1_q        <= '0;
      a2_q        <= '0;
      wcnt        <= '0;
      tcnt        <= '0;
      res_w       <= '0;
      res_ones    <= '0;
      res_ovf     <= 1'b0;
      res_timeout <= 1'b0;
      job_count   <= '0;
    end else begin
      state <= state_d;
      kick  <= accept;
      if (accept) begin
        a1_q        <= job_a1;
        a2_q        <= job_a2;
        res_w       <= '0;
        res_ones    <= '0;
        res_ovf     <= 1'b0;
        res_timeout <= 1'b0;
      end
      if (state_d != state)                      wcnt <= '0;
      else if (state == S_WAIT || state == S_GAP) wcnt <= wcnt + 1'b1;
      // Timeout window opens once the start write has fully completed.
      if (state == S_WR_GO && done) tcnt <= '0;
      else if ((state == S_WAIT || state == S_POLL || state == S_GAP) && !tmo)
        tcnt <= tcnt + 1'b1;
      if (state == S_POLL && done && rdata[STAT_READY]) res_ovf <= ~rdata[STAT_VALID];
      if (state == S_RD_W && done) res_w    <= rdata;
      if (state == S_RD_L && done) res_ones <= rdata[23:0];
      if (abort) res_timeout <= 1'b1;
      if (res_valid && res_ready) job_count <= job_count + 1'b1;
    end
  end

  gpio_bus_access #(
    .STROBE_CYCLES(STROBE_CYCLES)
  ) u_access (
    .clk      (clk),
    .n_reset  (n_reset),
    .start    (start),
    .rnw      (acc_rnw),
    .addr     (acc_addr),
    .wdata    (acc_wdata),
    .done     (done),
    .rdata    (rdata),
    .saddress (saddress),
    .swr      (swr),
    .srd      (srd),
    .sdata_wr (sdata_wr),
    .sdata_rd (bus.sdata_rd)
  );

  assign bus.saddress = saddress;
  assign bus.swr      = swr;
  assign bus.srd      = srd;
  assign bus.sdata_wr = sdata_wr;

endmodule
